// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES widths, SubBytes engine state type and the
//                byte-index helper (byte 0 in the most significant bits).
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // MSB position of byte idx inside a block; use as [aes_byte_msb(i) -: 8].
    function automatic int aes_byte_msb(input int idx);
        return AES_BLOCK_W - 1 - AES_BYTE_W * idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sbox
//  Description : Combinational AES inverse S-box (endereco -> dado).
//  Revision    : 1.0  initial release
// ============================================================================
module inv_sbox (
    input  logic [7:0] endereco,
    output logic [7:0] dado
);

    localparam logic [2047:0] c_inv_sbox_table = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [7:0] w_table [256];

    for (genvar i = 0; i < 256; i++) begin : g_entry
        assign w_table[i] = c_inv_sbox_table[2047 - 8 * i -: 8];
    end

    assign dado = w_table[endereco];

endmodule
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
//  Module      : sbox
//  Description : Combinational AES forward S-box (endereco -> dado).
//  Revision    : 1.0  initial release
// ============================================================================
module sbox (
    input  logic [7:0] endereco,
    output logic [7:0] dado
);

    // Entry 0 sits in the top byte of the table constant.
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] w_table [256];

    for (genvar i = 0; i < 256; i++) begin : g_entry
        assign w_table[i] = c_sbox_table[2047 - 8 * i -: 8];
    end

    assign dado = w_table[endereco];

endmodule
`default_nettype wire

// File: rtl/aes_subbytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes_subbytes_seq
//  Description : Sequential AES SubBytes engine, LANES bytes per cycle over
//                valid/ready in and out. Define AES_SUBBYTES_INV_EN to add the
//                inv_mode port and InvSubBytes support.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_state,
`ifdef AES_SUBBYTES_INV_EN
    input  logic                   inv_mode,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_state,
    output logic                   busy
);

    localparam int NBEATS = AES_NBYTES / LANES;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] work_q, work_d;
    logic [AES_BLOCK_W-1:0] w_work_sub;
    logic                   w_accept;

    logic [AES_BYTE_W-1:0]  w_byte [AES_NBYTES];
    logic [AES_BYTE_W-1:0]  w_fwd  [LANES];
    logic [AES_BYTE_W-1:0]  w_sub  [LANES];

`ifdef AES_SUBBYTES_INV_EN
    logic                   inv_q, inv_d;
    logic [AES_BYTE_W-1:0]  w_inv  [LANES];
`endif

    // Lane l serves byte cnt*LANES + l of the work register.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] w_idx;
        assign w_idx = 4'(int'(cnt_q) * LANES + l);

        sbox u_sbox (
            .endereco (w_byte[w_idx]),
            .dado     (w_fwd[l])
        );
`ifdef AES_SUBBYTES_INV_EN
        inv_sbox u_inv_sbox (
            .endereco (w_byte[w_idx]),
            .dado     (w_inv[l])
        );
        assign w_sub[l] = inv_q ? w_inv[l] : w_fwd[l];
`else
        assign w_sub[l] = w_fwd[l];
`endif
    end

    // Byte i belongs to beat i/LANES and is produced by lane i%LANES.
    for (genvar i = 0; i < AES_NBYTES; i++) begin : g_byte
        assign w_byte[i] = work_q[aes_byte_msb(i) -: AES_BYTE_W];
        assign w_work_sub[aes_byte_msb(i) -: AES_BYTE_W] =
            (cnt_q == CW'(i / LANES)) ? w_sub[i % LANES] : w_byte[i];
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_state = out_valid ? work_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
`ifdef AES_SUBBYTES_INV_EN
        inv_d   = inv_q;
`endif
        unique case (state_q)
            IDLE: ;
            BUSY: begin
                work_d = w_work_sub;
                if (cnt_q == CW'(NBEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides DONE->IDLE so a waiting block starts without a bubble.
        if (w_accept) begin
            state_d = BUSY;
            cnt_d   = '0;
            work_d  = in_state;
`ifdef AES_SUBBYTES_INV_EN
            inv_d   = inv_mode;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
`ifdef AES_SUBBYTES_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
`ifdef AES_SUBBYTES_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

endmodule
`default_nettype wire
